// File: rtl/regbank_wb16.sv
// regbank_wb16: write-back end of the register datapath.
// Write requests (select + data) enter a 2-entry in-order queue through a
// valid/ready handshake. The queue head commits into one of eight registers
// each cycle unless hold or clr is asserted. clr synchronously flushes the
// queue and zeroes all registers, and it takes priority over accept and commit.
module regbank_wb16 #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hold,
    input  logic             clr,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [7:0]       pending,
    output logic [1:0]       count,
    output logic             commit_valid,
    output logic [2:0]       commit_sel
);

    localparam int DEPTH = 2;

    // One-hot decode of a register select, used to build the pending mask.
    function automatic logic [7:0] sel_onehot(input logic [2:0] sel);
        sel_onehot = 8'b0000_0001 << sel;
    endfunction

    // Queue storage: entry 0 is always the head.
    logic [2:0]       ent_sel_q  [DEPTH];
    logic [2:0]       ent_sel_d  [DEPTH];
    logic [WIDTH-1:0] ent_data_q [DEPTH];
    logic [WIDTH-1:0] ent_data_d [DEPTH];
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    // Register file and commit report.
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             commit_valid_q;
    logic             commit_valid_d;
    logic [2:0]       commit_sel_q;
    logic [2:0]       commit_sel_d;

    logic             accept_s;
    logic             commit_s;
    logic [1:0]       fill_s;

    // Handshake and commit decisions; ready ignores hold and same-cycle commits.
    always_comb begin
        wr_ready = (count_q != 2'd2) && !clr;
        accept_s = wr_valid && wr_ready;
        commit_s = (count_q != 2'd0) && !hold && !clr;
    end

    // Pending mask: OR of one-hot selects over the occupied queue entries.
    always_comb begin
        pending = 8'h00;
        if (count_q != 2'd0) begin
            pending = pending | sel_onehot(ent_sel_q[0]);
        end else begin
            pending = 8'h00;
        end
        if (count_q == 2'd2) begin
            pending = pending | sel_onehot(ent_sel_q[1]);
        end else begin
            pending = pending;
        end
    end

    // Next state: clr flushes everything; otherwise pop the head on commit,
    // then append an accepted request at the first free slot.
    always_comb begin
        ent_sel_d      = ent_sel_q;
        ent_data_d     = ent_data_q;
        count_d        = count_q;
        regs_d         = regs_q;
        commit_valid_d = 1'b0;
        commit_sel_d   = commit_sel_q;
        fill_s         = count_q;
        if (clr) begin
            count_d = 2'd0;
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = {WIDTH{1'b0}};
            end
        end else begin
            if (commit_s) begin
                regs_d[ent_sel_q[0]] = ent_data_q[0];
                ent_sel_d[0]         = ent_sel_q[1];
                ent_data_d[0]        = ent_data_q[1];
                fill_s               = count_q - 2'd1;
                commit_valid_d       = 1'b1;
                commit_sel_d         = ent_sel_q[0];
            end else begin
                fill_s = count_q;
            end
            if (accept_s) begin
                // fill_s is 0 or 1 here: accept implies count_q < 2.
                ent_sel_d[fill_s[0]]  = wr_sel;
                ent_data_d[fill_s[0]] = wr_data;
                fill_s                = fill_s + 2'd1;
            end else begin
                fill_s = fill_s;
            end
            count_d = fill_s;
        end
    end

    // State registers; reset discards queued entries and zeroes the registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_sel_q[i]  <= 3'd0;
                ent_data_q[i] <= {WIDTH{1'b0}};
            end
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            count_q        <= 2'd0;
            commit_valid_q <= 1'b0;
            commit_sel_q   <= 3'd0;
        end else begin
            ent_sel_q      <= ent_sel_d;
            ent_data_q     <= ent_data_d;
            regs_q         <= regs_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_sel_q   <= commit_sel_d;
        end
    end

    // Output mapping.
    always_comb begin
        q0           = regs_q[0];
        q1           = regs_q[1];
        q2           = regs_q[2];
        q3           = regs_q[3];
        q4           = regs_q[4];
        q5           = regs_q[5];
        q6           = regs_q[6];
        q7           = regs_q[7];
        count        = count_q;
        commit_valid = commit_valid_q;
        commit_sel   = commit_sel_q;
    end

endmodule

// File: tb/tb_regbank_wb16.sv
// Bench for regbank_wb16: directed scenarios followed by random traffic.
// A queue-level reference model predicts registers, occupancy and pending;
// accepted requests go into a scoreboard that a separate monitor drains on
// every commit_valid.
module tb_regbank_wb16;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_sel = 3'd0;
    logic [15:0] wr_data = 16'h0000;
    logic        hold = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0]  pending;
    logic [1:0]  count;
    logic        commit_valid;
    logic [2:0]  commit_sel;

    logic [15:0] q_arr [8];
    assign q_arr[0] = q0;
    assign q_arr[1] = q1;
    assign q_arr[2] = q2;
    assign q_arr[3] = q3;
    assign q_arr[4] = q4;
    assign q_arr[5] = q5;
    assign q_arr[6] = q6;
    assign q_arr[7] = q7;

    regbank_wb16 dut (
        .CLK(CLK), .RSTN(RSTN),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_sel(wr_sel), .wr_data(wr_data),
        .hold(hold), .clr(clr),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .pending(pending), .count(count),
        .commit_valid(commit_valid), .commit_sel(commit_sel)
    );

    always #5 CLK = ~CLK;

    // Reference model state.
    ent_t        mq[$];      // requests in flight inside the DUT
    ent_t        sb_q[$];    // scoreboard: accepted, commit not yet observed
    logic [15:0] mregs [8];
    logic        exp_cv = 1'b0;
    logic [2:0]  exp_cs = 3'd0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0] p = 8'h00;
        foreach (mq[i]) p[mq[i].sel] = 1'b1;
        return p;
    endfunction

    // Compare every architecturally visible output with the model (at negedge).
    task automatic check_outputs();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("q%0d", i), {16'h0, q_arr[i]}, {16'h0, mregs[i]});
        end
        chk("count", {30'h0, count}, mq.size());
        chk("pending", {24'h0, pending}, {24'h0, model_pending()});
        chk("commit_valid", {31'h0, commit_valid}, {31'h0, exp_cv});
        chk("commit_sel", {29'h0, commit_sel}, {29'h0, exp_cs});
    endtask

    // One cycle: check outputs, drive inputs, advance the model to the next edge.
    task automatic step(input logic v, input logic [2:0] s, input logic [15:0] d,
                        input logic h, input logic c);
        bit do_commit;
        bit do_accept;
        ent_t e;
        check_outputs();
        wr_valid = v;
        wr_sel   = s;
        wr_data  = d;
        hold     = h;
        clr      = c;
        #1;
        chk("wr_ready", {31'h0, wr_ready}, {31'h0, (mq.size() < 2) && !c});
        if (c) begin
            mq.delete();
            sb_q.delete();
            for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
            exp_cv = 1'b0;
        end else begin
            do_accept = v && (mq.size() < 2);
            do_commit = (mq.size() > 0) && !h;
            if (do_commit) begin
                e = mq.pop_front();
                mregs[e.sel] = e.data;
                exp_cv = 1'b1;
                exp_cs = e.sel;
            end else begin
                exp_cv = 1'b0;
            end
            if (do_accept) begin
                e.sel  = s;
                e.data = d;
                mq.push_back(e);
                sb_q.push_back(e);
            end
        end
        @(negedge CLK);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic pulse_reset();
        #2;
        RSTN = 1'b0;
        #1;
        mq.delete();
        sb_q.delete();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        exp_cv = 1'b0;
        exp_cs = 3'd0;
        check_outputs();
        RSTN = 1'b1;
        @(negedge CLK);
    endtask

    // Monitor: on each reported commit, pop the oldest accepted request and compare.
    initial begin
        ent_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (RSTN && commit_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_commit_sel", {29'h0, commit_sel}, {29'h0, e.sel});
                    chk("sb_commit_data", {16'h0, q_arr[commit_sel]}, {16'h0, e.data});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        #12;
        RSTN = 1'b1;
        @(negedge CLK);

        // Single write after reset.
        step(1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Fill under hold; third request waits until space frees up.
        step(1'b1, 3'd1, 16'h1111, 1'b1, 1'b0);
        step(1'b1, 3'd2, 16'h2222, 1'b1, 1'b0);
        step(1'b1, 3'd5, 16'h5555, 1'b1, 1'b0);
        step(1'b1, 3'd5, 16'h5555, 1'b0, 1'b0);
        step(1'b1, 3'd5, 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Two writes to the same register keep order.
        step(1'b1, 3'd7, 16'h0001, 1'b1, 1'b0);
        step(1'b1, 3'd7, 16'h0002, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Streaming: accept and commit in the same cycle.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i[2:0], i[15:0] * 16'h1010, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // clr beats a concurrent request.
        step(1'b1, 3'd0, 16'h0A0A, 1'b1, 1'b0);
        step(1'b1, 3'd1, 16'h0B0B, 1'b1, 1'b0);
        step(1'b1, 3'd4, 16'hAAAA, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Reset mid-operation discards the queued entry.
        step(1'b1, 3'd6, 16'h6666, 1'b1, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                     16'($urandom), $urandom_range(0, 9) < 3,
                     $urandom_range(0, 39) == 0);
            end
        end

        // Drain and confirm every accepted request was reported.
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        check_outputs();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regbank_wb16.md
Name: regbank_wb16

Overview:
- Write-back end of the register datapath.
- Accepts 16-bit write requests (data plus 3-bit register select) through a valid/ready handshake and buffers them in a 2-entry in-order queue.
- Commits one queued write per cycle into one of eight 16-bit registers. Commits stall while hold is high.
- The eight register outputs drive the d0..d7 inputs of the operand mux-register stage. Per-register pending flags tell the issue logic which registers have writes in flight.

Parameters:
WIDTH, 16, data width of each register and of wr_data
NREG, 8, number of registers (fixed at 8; select width is 3)

Ports:
CLK  input  1  clock, all state updates on rising edge
RSTN  input  1  asynchronous active-low reset
wr_valid  input  1  write request valid
wr_ready  output  1  queue can accept a request this cycle
wr_sel  input  3  target register index
wr_data  input  16  write data
hold  input  1  stall commits (queue still accepts while not full)
clr  input  1  synchronous clear of registers and queue
q0..q7  output  16 each  register contents
pending  output  8  bit i = some queued entry targets register i
count  output  2  queued entries (0..2)
commit_valid  output  1  a commit occurred at the last clock edge
commit_sel  output  3  register index of that commit

Behaviour:
- Interface: one clock CLK; reset RSTN is asynchronous, active-low.
- Reset (RSTN=0, async):
  - q0..q7 = 0.
  - Queue emptied: count=0, pending=0.
  - commit_valid=0, commit_sel=0.
  - After reset release, wr_ready=1 (when clr=0).
- Handshake:
  - wr_ready = (count<2) && !clr. Combinational; does not depend on hold or on a same-cycle commit.
  - Accept occurs when wr_valid && wr_ready at the rising edge. The entry is appended at the tail.
  - wr_valid with wr_ready=0 has no effect. The requester holds its request until accepted.
- Commit:
  - When count>0 && !hold && !clr, the head entry writes q[head.sel] <= head.data at the edge and is popped.
  - Latency: a request accepted at edge N commits at edge N+1 at the earliest. Its data is visible on q after edge N+1.
  - Strictly in order, one commit per cycle.
  - Consecutive writes to the same register both commit; the later one wins.
- Queue occupancy:
  - Accept and commit in the same cycle: count unchanged, entries shift correctly.
  - count=2 with a commit this cycle: no accept (wr_ready=0); count becomes 1.
  - count=0 with an accept: no commit that cycle; count becomes 1.
- pending: combinational OR over valid entries of a one-hot decode of sel. With two entries to the same register, that bit is set until both have committed.
- commit_valid / commit_sel: registered. commit_valid is 1 for exactly the cycle after each commit edge, otherwise 0. commit_sel holds its last value when commit_valid=0.
- clr (synchronous, highest priority): at the edge, q0..q7 <= 0, queue flushed, count=0, commit_valid <= 0. No accept and no commit happen in a clr cycle.
- hold=1: registers frozen; queue fills up to 2 entries, then wr_ready=0.
- Reset asserted mid-operation: queued entries are discarded and are never committed.
- Every register updates only through commit, clr or reset.

Test Plan:
1. Reset then single write:
   - Stimulus: RSTN low, release; wr_valid=1, wr_sel=3, wr_data=16'hBEEF for one cycle.
   - Required: wr_ready=1; pending=8'h08 for one cycle; q3=BEEF after the next edge; commit_valid=1 with commit_sel=3 for one cycle; all other q = 0.
2. Fill under hold:
   - Stimulus: hold=1; writes (1,0x1111), (2,0x2222), (5,0x5555) presented back-to-back.
   - Required: first two accepted; count=2, wr_ready=0, pending=8'h06; third request held until hold is dropped.
   - After hold=0: commits q1, q2, then q5 on successive edges.
3. Same-register ordering:
   - Stimulus: hold=1; write (7,0x0001) then (7,0x0002); release hold.
   - Required: pending[7]=1 until the second commit; q7 goes 0001 then 0002; final q7=0002.
4. Simultaneous accept and commit:
   - Stimulus: continuous wr_valid with sel 0..7, data=sel*0x1010, hold=0.
   - Required: count stays 1 in steady state, one commit per cycle, q_i = i*0x1010 at the end.
5. clr priority:
   - Stimulus: two entries queued under hold; assert clr=1 together with wr_valid=1 (sel 4, 0xAAAA).
   - Required: wr_ready=0 that cycle; next cycle count=0, pending=0, all q=0, q4 stays 0.
6. Reset mid-operation:
   - Stimulus: queue holds (6,0x6666) under hold; pulse RSTN low asynchronously between edges.
   - Required: all outputs 0 immediately; after release and hold=0, q6 remains 0.
